// File: rtl/mmul_pkg.sv
// Shared types for the matrix-multiply sequencer: data word width and controller state encoding.
package mmul_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KICK = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mmul_seq_if.sv
// Source-memory, multiplier-FIFO and result-sink signals of mmul_seq, seen from the sequencer (master)
// and from its environment (slave).
interface mmul_seq_if
  import mmul_pkg::*;
#(
  parameter int AW = 3
) ();

  logic [AW-1:0] src_addr;
  logic          src_rd_en;
  word_t         src_a_data;
  word_t         src_b_data;

  logic          fA_write_ready;
  logic          fB_write_ready;
  logic          fC_read_ready;
  logic          fA_write_enable;
  logic          fB_write_enable;
  logic          fC_read_enable;
  word_t         fA_write_data;
  word_t         fB_write_data;
  word_t         fC_read_data;

  logic [AW-1:0] dst_addr;
  logic          dst_wr_en;
  word_t         dst_wr_data;

  modport master (
    output src_addr, src_rd_en,
    input  src_a_data, src_b_data,
    input  fA_write_ready, fB_write_ready, fC_read_ready,
    output fA_write_enable, fB_write_enable, fC_read_enable,
    output fA_write_data, fB_write_data,
    input  fC_read_data,
    output dst_addr, dst_wr_en, dst_wr_data
  );

  modport slave (
    input  src_addr, src_rd_en,
    output src_a_data, src_b_data,
    output fA_write_ready, fB_write_ready, fC_read_ready,
    input  fA_write_enable, fB_write_enable, fC_read_enable,
    input  fA_write_data, fB_write_data,
    output fC_read_data,
    input  dst_addr, dst_wr_en, dst_wr_data
  );

endinterface

// File: rtl/mmul_seq_loader.sv
// Load engine: reads A/B pairs from source memory into a one-entry hold register and pushes each
// pair into the A and B FIFOs together, only when both report ready.
module mmul_seq_loader
  import mmul_pkg::*;
#(
  parameter int ORDER = 64,
  parameter int AW    = $clog2(ORDER*ORDER+1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr_i,
  input  logic          run_i,
  output logic          src_rd_en_o,
  output logic [AW-1:0] src_addr_o,
  input  word_t         src_a_data_i,
  input  word_t         src_b_data_i,
  input  logic          fA_write_ready_i,
  input  logic          fB_write_ready_i,
  output logic          fA_write_enable_o,
  output logic          fB_write_enable_o,
  output word_t         fA_write_data_o,
  output word_t         fB_write_data_o,
  output logic [AW-1:0] wr_cnt_o
);

  localparam logic [AW-1:0] N_WORDS = AW'(ORDER*ORDER);

  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          pend_q, pend_d;
  logic          hold_vld_q, hold_vld_d;
  word_t         hold_a_q, hold_a_d;
  word_t         hold_b_q, hold_b_d;
  logic          pop;
  logic          rd;

  // A read in flight owns the hold slot, so a returning pair always has somewhere to land.
  assign pop = run_i && hold_vld_q && fA_write_ready_i && fB_write_ready_i;
  assign rd  = run_i && (rd_cnt_q < N_WORDS) && !pend_q && (!hold_vld_q || pop);

  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    pend_d     = pend_q;
    hold_vld_d = hold_vld_q;
    hold_a_d   = hold_a_q;
    hold_b_d   = hold_b_q;
    if (clr_i) begin
      rd_cnt_d   = '0;
      wr_cnt_d   = '0;
      pend_d     = 1'b0;
      hold_vld_d = 1'b0;
    end else begin
      pend_d = rd;
      if (rd) rd_cnt_d = rd_cnt_q + 1'b1;
      if (pop) begin
        hold_vld_d = 1'b0;
        wr_cnt_d   = wr_cnt_q + 1'b1;
      end
      if (pend_q) begin
        hold_vld_d = 1'b1;
        hold_a_d   = src_a_data_i;
        hold_b_d   = src_b_data_i;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      pend_q     <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      pend_q     <= pend_d;
      hold_vld_q <= hold_vld_d;
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
    end
  end

  assign src_rd_en_o       = rd;
  assign src_addr_o        = rd ? rd_cnt_q : '0;
  assign fA_write_enable_o = pop;
  assign fB_write_enable_o = pop;
  assign fA_write_data_o   = pop ? hold_a_q : '0;
  assign fB_write_data_o   = pop ? hold_b_q : '0;
  assign wr_cnt_o          = wr_cnt_q;

endmodule

// File: rtl/mmul_seq.sv
// Matrix-multiply job sequencer: kicks the multiplier, feeds A/B, drains C to the sink.
// Define MMUL_SEQ_CHECKSUM_EN to build the running checksum of drained C words.
//   state | meaning
//   IDLE  | waiting for first START
//   KICK  | one-cycle m_START pulse
//   RUN   | load and drain engines active
//   DONE  | job complete, results and checksum held
module mmul_seq
  import mmul_pkg::*;
#(
  parameter int ORDER = 64,
  parameter int AW    = $clog2(ORDER*ORDER+1)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  output logic        Busy,
  output logic        Done,
  output logic        m_START,
  output word_t       checksum,
  mmul_seq_if.master  bus
);

  localparam logic [AW-1:0] N_WORDS = AW'(ORDER*ORDER);

  state_e        state_q, state_d;
  logic [AW-1:0] rd_c_q, rd_c_d;
  logic [AW-1:0] wr_cnt;
  logic          start_acc;
  logic          run;
  logic          drain;

  assign start_acc = START && ((state_q == IDLE) || (state_q == DONE));
  assign run       = (state_q == RUN);
  assign drain     = run && (rd_c_q < N_WORDS) && bus.fC_read_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_acc) state_d = KICK;
      KICK:       state_d = RUN;
      RUN:        if ((wr_cnt == N_WORDS) && (rd_c_q == N_WORDS)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_c_d = rd_c_q;
    if (start_acc)  rd_c_d = '0;
    else if (drain) rd_c_d = rd_c_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      rd_c_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_c_q  <= rd_c_d;
    end
  end

  mmul_seq_loader #(
    .ORDER (ORDER),
    .AW    (AW)
  ) u_loader (
    .CLK               (CLK),
    .RST               (RST),
    .clr_i             (start_acc),
    .run_i             (run),
    .src_rd_en_o       (bus.src_rd_en),
    .src_addr_o        (bus.src_addr),
    .src_a_data_i      (bus.src_a_data),
    .src_b_data_i      (bus.src_b_data),
    .fA_write_ready_i  (bus.fA_write_ready),
    .fB_write_ready_i  (bus.fB_write_ready),
    .fA_write_enable_o (bus.fA_write_enable),
    .fB_write_enable_o (bus.fB_write_enable),
    .fA_write_data_o   (bus.fA_write_data),
    .fB_write_data_o   (bus.fB_write_data),
    .wr_cnt_o          (wr_cnt)
  );

  assign bus.fC_read_enable = drain;
  assign bus.dst_wr_en      = drain;
  assign bus.dst_addr       = drain ? rd_c_q : '0;
  assign bus.dst_wr_data    = drain ? bus.fC_read_data : '0;

  assign Busy    = (state_q == KICK) || (state_q == RUN);
  assign Done    = (state_q == DONE);
  assign m_START = (state_q == KICK);

`ifdef MMUL_SEQ_CHECKSUM_EN
  word_t sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_acc)  sum_d = '0;
    else if (drain) sum_d = sum_q + bus.fC_read_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sum_q <= '0;
    else      sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mmul_seq.sv
// Bench for mmul_seq at ORDER=2: source memory, FIFO-ready patterns and a C-word stream, with every
// strobe cycle checked against in-order expectations derived from the memory and C-word arrays.
module tb_mmul_seq;
  import mmul_pkg::*;

  localparam int ORDER = 2;
  localparam int N     = ORDER * ORDER;
  localparam int AW    = 3;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  START = 1'b0;
  logic  Busy, Done, m_START;
  word_t checksum;

  mmul_seq_if #(.AW(AW)) bus ();

  mmul_seq #(.ORDER(ORDER), .AW(AW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .Busy     (Busy),
    .Done     (Done),
    .m_START  (m_START),
    .checksum (checksum),
    .bus      (bus.master)
  );

  always #5 CLK = ~CLK;

  int    nvec = 0;
  int    nerr = 0;
  word_t memA [N];
  word_t memB [N];
  word_t cw   [N];
  word_t obsA [N];
  word_t obsB [N];
  word_t obsD [N];
  int    a_idx = 0, b_idx = 0, d_idx = 0, r_idx = 0;
  word_t sum_m = '0;
  int    cyc = 0;
  int    c_ptr = 0;
  int    rmode = 0;
  int    stall_from = -100;
  logic  fc_tog = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  function automatic word_t exp_checksum(input word_t s);
`ifdef MMUL_SEQ_CHECKSUM_EN
    return s;
`else
    return (s & 32'h0);
`endif
  endfunction

  // Source memory: data for the address read in one cycle appears in the next.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (bus.src_rd_en) begin
      bus.src_a_data <= memA[int'(bus.src_addr) % N];
      bus.src_b_data <= memB[int'(bus.src_addr) % N];
    end
    if (m_START)                 c_ptr <= 0;
    else if (bus.fC_read_enable) c_ptr <= c_ptr + 1;
  end

  assign bus.fC_read_data = cw[c_ptr % N];

  always @(posedge CLK) begin
    #1;
    case (rmode)
      0: begin
        bus.fA_write_ready = 1'b1;
        bus.fB_write_ready = 1'b1;
        bus.fC_read_ready  = 1'b1;
      end
      1: begin
        bus.fA_write_ready = 1'b1;
        bus.fB_write_ready = !((cyc >= stall_from) && (cyc < stall_from + 5));
        bus.fC_read_ready  = 1'b1;
      end
      2: begin
        fc_tog = ~fc_tog;
        bus.fA_write_ready = 1'b1;
        bus.fB_write_ready = 1'b1;
        bus.fC_read_ready  = fc_tog;
      end
      default: begin
        bus.fA_write_ready = ($urandom_range(0, 3) != 0);
        bus.fB_write_ready = ($urandom_range(0, 3) != 0);
        bus.fC_read_ready  = ($urandom_range(0, 2) != 0);
      end
    endcase
  end

  always @(negedge CLK) begin
    if (m_START || !RST) begin
      a_idx = 0; b_idx = 0; d_idx = 0; r_idx = 0;
      sum_m = '0;
    end
    chk("checksum", checksum, exp_checksum(sum_m));
    chk1("pair_enable", bus.fB_write_enable, bus.fA_write_enable);
    if (!Busy)
      chk("idle_strobes", 32'({bus.src_rd_en, bus.fA_write_enable, bus.fB_write_enable,
                               bus.fC_read_enable, bus.dst_wr_en}), 32'h0);
    if (bus.src_rd_en) begin
      chk("src_addr", 32'(bus.src_addr), 32'(r_idx));
      r_idx++;
    end
    if (bus.fA_write_enable) begin
      chk1("fA_both_ready", bus.fA_write_ready & bus.fB_write_ready, 1'b1);
      if (a_idx < N) begin
        chk("fA_data", bus.fA_write_data, memA[a_idx]);
        obsA[a_idx] = bus.fA_write_data;
      end else chk("fA_extra_write", 32'(a_idx), 32'(N - 1));
      a_idx++;
    end
    if (bus.fB_write_enable) begin
      if (b_idx < N) begin
        chk("fB_data", bus.fB_write_data, memB[b_idx]);
        obsB[b_idx] = bus.fB_write_data;
      end else chk("fB_extra_write", 32'(b_idx), 32'(N - 1));
      b_idx++;
    end
    if (bus.dst_wr_en) begin
      chk1("drain_fc_enable", bus.fC_read_enable, 1'b1);
      chk1("drain_fc_ready", bus.fC_read_ready, 1'b1);
      if (d_idx < N) begin
        chk("dst_addr", 32'(bus.dst_addr), 32'(d_idx));
        chk("dst_data", bus.dst_wr_data, cw[d_idx]);
        obsD[d_idx] = bus.dst_wr_data;
      end else chk("dst_extra_write", 32'(d_idx), 32'(N - 1));
      sum_m = sum_m + bus.dst_wr_data;
      d_idx++;
    end
  end

  task automatic run_job(input string tag, input bit poke);
    int budget;
    @(posedge CLK); #1 START = 1'b1;
    @(negedge CLK); #1;
    chk1({tag, "_mstart_pre"}, m_START, 1'b0);
    @(posedge CLK); #1 START = 1'b0;
    @(negedge CLK); #1;
    chk1({tag, "_mstart"}, m_START, 1'b1);
    chk1({tag, "_busy_kick"}, Busy, 1'b1);
    chk1({tag, "_done_drop"}, Done, 1'b0);
    @(negedge CLK); #1;
    chk1({tag, "_mstart_once"}, m_START, 1'b0);
    if (poke) begin
      @(posedge CLK); #1 START = 1'b1;
      @(posedge CLK); #1 START = 1'b0;
      @(negedge CLK); #1;
      chk1({tag, "_poke_busy"}, Busy, 1'b1);
      chk1({tag, "_poke_mstart"}, m_START, 1'b0);
    end
    budget = 0;
    while (!((a_idx >= N) && (b_idx >= N) && (d_idx >= N)) && (budget < 300)) begin
      @(negedge CLK); #1;
      budget++;
    end
    if (budget >= 300) begin
      chk({tag, "_timeout"}, 32'(a_idx + b_idx + d_idx), 32'(3 * N));
      return;
    end
    // START lands exactly in the RUN->DONE cycle and must be ignored.
    @(posedge CLK); #1 START = 1'b1;
    @(negedge CLK); #1;
    chk1({tag, "_busy_last"}, Busy, 1'b1);
    chk1({tag, "_done_last"}, Done, 1'b0);
    @(posedge CLK); #1 START = 1'b0;
    @(negedge CLK); #1;
    chk1({tag, "_done"}, Done, 1'b1);
    chk1({tag, "_busy_end"}, Busy, 1'b0);
    chk1({tag, "_no_restart"}, m_START, 1'b0);
    chk({tag, "_counts"}, 32'({8'(a_idx), 8'(b_idx), 8'(d_idx), 8'(r_idx)}),
        32'({8'(N), 8'(N), 8'(N), 8'(N)}));
    @(negedge CLK); #1;
    chk1({tag, "_done_hold"}, Done, 1'b1);
  endtask

  task automatic default_mem();
    for (int i = 0; i < N; i++) begin
      memA[i] = word_t'(i);
      memB[i] = word_t'(10 + i);
      cw[i]   = word_t'(5 + i);
    end
  endtask

  initial begin
    int budget;
    default_mem();
    #2 RST = 1'b0;
    @(negedge CLK); #1;
    chk("reset_outputs", 32'({Busy, Done, m_START, bus.src_rd_en, bus.src_addr, bus.fA_write_enable,
                              bus.fB_write_enable, bus.fC_read_enable, bus.dst_wr_en, bus.dst_addr}), 32'h0);
    chk("reset_checksum", checksum, 32'h0);
    @(negedge CLK); #1 RST = 1'b1;
    repeat (4) begin
      @(negedge CLK); #1;
      chk("post_reset_quiet", 32'({Busy, Done, m_START, bus.src_rd_en}), 32'h0);
    end

    rmode = 0;
    run_job("basic", 1'b0);
    for (int i = 0; i < N; i++) begin
      chk("basic_lit_A", obsA[i], word_t'(i));
      chk("basic_lit_B", obsB[i], word_t'(10 + i));
    end

    rmode = 1;
    stall_from = cyc + 5;
    run_job("fb_stall", 1'b0);
    for (int i = 0; i < N; i++) begin
      chk("stall_lit_A", obsA[i], word_t'(i));
      chk("stall_lit_B", obsB[i], word_t'(10 + i));
    end

    rmode = 2;
    run_job("fc_toggle", 1'b0);
    for (int i = 0; i < N; i++) chk("toggle_lit_D", obsD[i], word_t'(5 + i));
`ifdef MMUL_SEQ_CHECKSUM_EN
    chk("toggle_lit_checksum", checksum, 32'd26);
`else
    chk("toggle_lit_checksum", checksum, 32'd0);
`endif

    rmode = 0;
    run_job("poke_busy", 1'b1);
    run_job("second_job", 1'b0);
    for (int i = 0; i < N; i++) chk("second_lit_A", obsA[i], word_t'(i));

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        memA[i] = $urandom;
        memB[i] = $urandom;
        cw[i]   = $urandom;
      end
      rmode = 3;
      run_job("random", k[0]);
    end

    default_mem();
    rmode = 0;
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    budget = 0;
    while ((r_idx < 2) && (budget < 50)) begin
      @(negedge CLK); #1;
      budget++;
    end
    chk("midrun_two_loads", 32'(r_idx >= 2), 32'h1);
    #2 RST = 1'b0;
    #1;
    chk("midrun_reset_ctrl", 32'({Busy, Done, m_START, bus.src_rd_en, bus.src_addr, bus.fA_write_enable,
                                  bus.fB_write_enable, bus.fC_read_enable, bus.dst_wr_en, bus.dst_addr}), 32'h0);
    chk("midrun_reset_data", bus.fA_write_data | bus.fB_write_data | bus.dst_wr_data | checksum, 32'h0);
    @(negedge CLK);
    @(negedge CLK); #1 RST = 1'b1;
    repeat (4) begin
      @(negedge CLK); #1;
      chk("after_reset_quiet", 32'({Busy, Done, m_START, bus.src_rd_en, bus.fC_read_enable}), 32'h0);
    end
    run_job("restart", 1'b0);
    for (int i = 0; i < N; i++) chk("restart_lit_A", obsA[i], word_t'(i));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
